// File: rtl/mc_ctrl_pkg.sv
// Shared types for the multicycle MIPS main controller: state codes, opcodes,
// datapath select encodings and the per-state control decode.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_LUIEX   = 4'd12,
    S_SLTIEX  = 4'd13,
    S_BLEZBR  = 4'd14,
    S_TRAP    = 4'd15
  } statetype_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [2:0] {
    SRCB_B      = 3'b000,
    SRCB_FOUR   = 3'b001,
    SRCB_IMM    = 3'b010,
    SRCB_IMMSH2 = 3'b011,
    SRCB_IMMHI  = 3'b100
  } alusrcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_SLT   = 2'b11
  } aluop_t;

  // fetch marks the state whose irwrite/pcwrite follow mem_ready
  typedef struct packed {
    logic     iord;
    logic     fetch;
    logic     pcwrite;
    logic     branch;
    logic     blez;
    logic     memwrite;
    logic     regwrite;
    logic     regdst;
    logic     memtoreg;
    logic     alusrca;
    alusrcb_t alusrcb;
    pcsrc_t   pcsrc;
    aluop_t   aluop;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(input statetype_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.fetch = 1'b1; c.alusrcb = SRCB_FOUR; end
      S_DECODE:  c.alusrcb = SRCB_IMMSH2;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      S_EXECUTE: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      S_ALUWB:   begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      S_BRANCH:  begin
        c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.branch = 1'b1; c.pcsrc = PCSRC_ALUOUT;
      end
      S_BLEZBR:  begin
        c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.blez = 1'b1; c.pcsrc = PCSRC_ALUOUT;
      end
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
      S_SLTIEX:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; c.aluop = ALUOP_SLT; end
      S_LUIEX:   begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMMHI; end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JUMP:    begin c.pcsrc = PCSRC_JUMP; c.pcwrite = 1'b1; end
      default:   ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath bundle: instruction opcode and memory handshake in,
// datapath strobes/selects and status out.
interface mc_ctrl_fsm_if;
  logic [5:0] op;
  logic       mem_ready;
  logic       iord;
  logic       irwrite;
  logic       pcwrite;
  logic       branch;
  logic       blez;
  logic       memwrite;
  logic       regwrite;
  logic       regdst;
  logic       memtoreg;
  logic       alusrca;
  logic [2:0] alusrcb;
  logic [1:0] pcsrc;
  logic [1:0] aluop;
  logic [3:0] state_o;
  logic       illegal;
  logic       mem_timeout;

  modport master (
    input  op, mem_ready,
    output iord, irwrite, pcwrite, branch, blez, memwrite, regwrite, regdst,
           memtoreg, alusrca, alusrcb, pcsrc, aluop, state_o, illegal, mem_timeout
  );

  modport slave (
    output op, mem_ready,
    input  iord, irwrite, pcwrite, branch, blez, memwrite, regwrite, regdst,
           memtoreg, alusrca, alusrcb, pcsrc, aluop, state_o, illegal, mem_timeout
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts not-ready cycles in a memory state and flags
// expiry when the count has reached TO_CYC (TO_CYC = 0 disables expiry).
module mc_wait_timer #(
  parameter int unsigned TO_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic tick,
  output logic expired
);
  localparam int unsigned TO_W = (TO_CYC > 0) ? $clog2(TO_CYC + 1) : 1;
  localparam logic [TO_W-1:0] LIMIT = TO_W'(TO_CYC);

  logic [TO_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (tick && (cnt_q != '1)) begin
      cnt_q <= cnt_q + TO_W'(1);
    end
  end

  // tick is low when mem_ready is high, so a ready in the limit cycle wins
  assign expired = (TO_CYC != 0) && tick && (cnt_q == LIMIT);
endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS main controller (Moore FSM, registered state-decoded outputs).
// Build option MC_ILLEGAL_TRAP_EN: undefined opcodes trap and set sticky illegal.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned TO_CYC = 16
) (
  input logic           clk,
  input logic           reset,
  mc_ctrl_fsm_if.master bus
);
  statetype_t state_q, state_d;
  ctrl_t      ctrl_q;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       mem_state, tick, clr, expired;

  assign mem_state = state_q inside {S_FETCH, S_MEMRD, S_MEMWR};
  assign tick      = mem_state & ~bus.mem_ready;
  assign clr       = bus.mem_ready | (state_d != state_q);

  mc_wait_timer #(.TO_CYC(TO_CYC)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .tick    (tick),
    .expired (expired)
  );

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    if (expired) begin
      state_d   = S_TRAP;
      timeout_d = 1'b1;
    end else begin
      case (state_q)
        S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
        S_DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_EXECUTE;
            OP_BEQ:       state_d = S_BRANCH;
            OP_BLEZ:      state_d = S_BLEZBR;
            OP_ADDI:      state_d = S_ADDIEX;
            OP_SLTI:      state_d = S_SLTIEX;
            OP_LUI:       state_d = S_LUIEX;
            OP_J:         state_d = S_JUMP;
            default: begin
`ifdef MC_ILLEGAL_TRAP_EN
              state_d   = S_TRAP;
              illegal_d = 1'b1;
`else
              state_d   = S_FETCH;
`endif
            end
          endcase
        end
        S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
        S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
        S_EXECUTE: state_d = S_ALUWB;
        S_ADDIEX, S_SLTIEX, S_LUIEX: state_d = S_ADDIWB;
        S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_BLEZBR, S_JUMP: state_d = S_FETCH;
        S_TRAP:   state_d = S_TRAP;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  // Outputs are registered from the next state so they align with state_q.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= ctrl_of(S_FETCH);
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_of(state_d);
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.iord        = ctrl_q.iord;
  assign bus.irwrite     = ctrl_q.fetch & bus.mem_ready & ~reset;
  assign bus.pcwrite     = ctrl_q.pcwrite | (ctrl_q.fetch & bus.mem_ready & ~reset);
  assign bus.branch      = ctrl_q.branch;
  assign bus.blez        = ctrl_q.blez;
  assign bus.memwrite    = ctrl_q.memwrite;
  assign bus.regwrite    = ctrl_q.regwrite;
  assign bus.regdst      = ctrl_q.regdst;
  assign bus.memtoreg    = ctrl_q.memtoreg;
  assign bus.alusrca     = ctrl_q.alusrca;
  assign bus.alusrcb     = ctrl_q.alusrcb;
  assign bus.pcsrc       = ctrl_q.pcsrc;
  assign bus.aluop       = ctrl_q.aluop;
  assign bus.state_o     = state_q;
  assign bus.illegal     = illegal_q;
  assign bus.mem_timeout = timeout_q;
endmodule
